// File: rtl/mux_arb_nto1.sv
// ---------------------------------------------------------------------------
// mux_arb_nto1
//
// Registered N-to-1 selector with valid/ready handshaking on every input
// channel and on the output. Merges several producers (e.g. writeback or
// result sources) onto one shared consumer through a single-entry output
// register. Supports an arbitration policy and a manual-select override.
//
// Optional feature macro: MUX_ARB_RR_EN
//   defined     -> round-robin arbitration starting at pointer r_ptr
//   not defined -> fixed priority, lowest eligible index wins (no pointer)
//
// Parameters:
//   WIDTH     data width per channel
//   CHANNELS  number of input channels (2..16)
//   SEL_W     index width, must equal clog2(CHANNELS)
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst        asynchronous active-high reset
//   i_in         flattened channel data, channel k at [k*WIDTH +: WIDTH]
//   i_inValid    per-channel data valid
//   o_inReady    per-channel accept (combinational, at most one bit set)
//   i_forceEn    manual-select mode enable
//   i_forceSel   channel selected when i_forceEn=1
//   o_out        registered output data
//   o_outValid   o_out holds a word not yet taken
//   i_outReady   consumer accepts o_out this cycle
//   o_outSrc     index of the channel that produced o_out
// ---------------------------------------------------------------------------
module mux_arb_nto1 #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [CHANNELS*WIDTH-1:0] i_in,
  input  logic [CHANNELS-1:0]       i_inValid,
  output logic [CHANNELS-1:0]       o_inReady,
  input  logic                      i_forceEn,
  input  logic [SEL_W-1:0]          i_forceSel,
  output logic [WIDTH-1:0]          o_out,
  output logic                      o_outValid,
  input  logic                      i_outReady,
  output logic [SEL_W-1:0]          o_outSrc
);

  logic [WIDTH-1:0]    r_out;
  logic                r_outValid;
  logic [SEL_W-1:0]    r_outSrc;

  logic [WIDTH-1:0]    w_chData [CHANNELS];
  logic [CHANNELS-1:0] w_elig;
  logic [SEL_W-1:0]    w_grantIdx;
  logic                w_grantAny;
  logic                w_load;
  logic                w_xfer;

`ifdef MUX_ARB_RR_EN
  logic [SEL_W-1:0]    r_ptr;
  logic [SEL_W-1:0]    w_scanIdx;
`endif

  // Unpack the flattened data bus so the selected word can be indexed directly.
  for (genvar gk = 0; gk < CHANNELS; gk++) begin : g_unpack
    assign w_chData[gk] = i_in[gk*WIDTH +: WIDTH];
  end

  // The output register can take a new word when it is empty or being drained.
  assign w_load = !r_outValid || i_outReady;

  // In force mode only the selected channel may compete; a select value beyond
  // the last channel matches no index, leaving the set empty.
  always_comb begin
    w_elig = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (i_forceEn) begin
        w_elig[k] = i_inValid[k] && (i_forceSel == SEL_W'(k));
      end else begin
        w_elig[k] = i_inValid[k];
      end
    end
  end

`ifdef MUX_ARB_RR_EN
  // Round-robin: scan from r_ptr with wrap-around, first eligible channel wins.
  always_comb begin
    w_grantIdx = '0;
    w_grantAny = 1'b0;
    w_scanIdx  = '0;
    for (int off = 0; off < CHANNELS; off++) begin
      w_scanIdx = SEL_W'((int'(r_ptr) + off) % CHANNELS);
      if (!w_grantAny && w_elig[w_scanIdx]) begin
        w_grantAny = 1'b1;
        w_grantIdx = w_scanIdx;
      end
    end
  end
`else
  // Fixed priority: lowest eligible index wins.
  always_comb begin
    w_grantIdx = '0;
    w_grantAny = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (!w_grantAny && w_elig[k]) begin
        w_grantAny = 1'b1;
        w_grantIdx = SEL_W'(k);
      end
    end
  end
`endif

  assign w_xfer = w_load && w_grantAny;

  // Ready is held low during reset so nothing is accepted while state is cleared.
  always_comb begin
    o_inReady = '0;
    if (w_xfer && !i_rst) begin
      o_inReady[w_grantIdx] = 1'b1;
    end
  end

  // Single-entry output register. A load replaces a word being drained in the
  // same cycle; a drain without a load only clears valid, data and source hold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out      <= '0;
      r_outValid <= 1'b0;
      r_outSrc   <= '0;
    end else if (w_xfer) begin
      r_out      <= w_chData[w_grantIdx];
      r_outSrc   <= w_grantIdx;
      r_outValid <= 1'b1;
    end else if (i_outReady) begin
      r_outValid <= 1'b0;
    end
  end

`ifdef MUX_ARB_RR_EN
  // Pointer moves past the channel just served; forced transfers leave it alone.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (w_xfer && !i_forceEn) begin
      if (w_grantIdx == SEL_W'(CHANNELS - 1)) begin
        r_ptr <= '0;
      end else begin
        r_ptr <= w_grantIdx + SEL_W'(1);
      end
    end
  end
`endif

  assign o_out      = r_out;
  assign o_outValid = r_outValid;
  assign o_outSrc   = r_outSrc;

endmodule
